vlsu_sequencer: RTL
===================

Name: vlsu_sequencer

Overview:
Sequences a decoded unit-stride vector load or store (vmem_read/vmem_write, vector width code, vm bit from the control unit) into a series of scalar-width memory beats on the single data-memory port. It captures one request, issues beats one at a time with a req/gnt/rvalid handshake, and merges load beats into a VLEN-bit buffer. It then writes that buffer to the vector register file. It sits between decode/issue and the data memory, and holds busy_o to stall the scalar pipeline while it owns the memory port.

Parameters:
DATA_WIDTH, 32, memory port data width; the maximum beat size.
ADDR_WIDTH, 32, byte address width.
VLEN, 128, vector register width in bits; a multiple of 64.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  vector memory op pending
req_ready_o  out  1  sequencer can accept a request
req_is_store_i  in  1  1 = store (vmem_write), 0 = load (vmem_read)
req_width_i  in  2  element width: 00 = e8, 01 = e16, 10 = e32, 11 = e64
req_base_i  in  ADDR_WIDTH  base address (rs1)
req_vd_i  in  5  destination or source vector register index
req_vm_i  in  1  1 = unmasked, 0 = masked by mask_i (same encoding as instr[25])
mask_i  in  VLEN/8  per-element active bits; bit e = element e
data_i  in  VLEN  store: vs3 value; load: old vd value, used for masked-off elements
mem_req_o  out  1  beat request
mem_we_o  out  1  write beat
mem_addr_o  out  ADDR_WIDTH  beat byte address
mem_size_o  out  2  00 = byte, 01 = half, 10 = word
mem_wdata_o  out  DATA_WIDTH  right-justified store data
mem_gnt_i  in  1  memory accepted the beat
mem_rvalid_i  in  1  beat response (load data or store acknowledge)
mem_rdata_i  in  DATA_WIDTH  right-justified load data
vrf_we_o  out  1  vector register write strobe
vrf_waddr_o  out  5  vector register write index
vrf_wdata_o  out  VLEN  merged load result
busy_o  out  1  sequencer owns the memory port
done_o  out  1  one-cycle completion pulse
err_o  out  1  misalignment error; valid with done_o (macro only, else tied 0)

Behaviour:
- Beat size:
  - beat_bits = min(element bits, DATA_WIDTH). For e64 with DATA_WIDTH = 32, beats are 32-bit.
  - num_beats = VLEN/beat_bits.
  - Beat index i covers element i*beat_bits/element bits.
  - Beat address = base + i*(beat_bits/8), modulo 2^ADDR_WIDTH (wrap-around permitted).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, capture all request fields, set beat index to 0, go to ISSUE.
- ISSUE, current beat's element active (req_vm = 1, or mask bit = 1):
  - Assert mem_req_o with we, addr, size and wdata.
  - Hold all request outputs stable until mem_gnt_i. On gnt, go to WAIT.
- ISSUE, current beat's element inactive:
  - No request; advance the index (1 cycle per skipped beat).
  - If this was the last beat, go to DONE.
- WAIT:
  - mem_req_o = 0. On mem_rvalid_i:
    - Load: write the low beat_bits of rdata into buffer[i*beat_bits +: beat_bits].
    - If last beat, go to DONE; else increment index and go to ISSUE.
  - mem_gnt_i and mem_rvalid_i may fall in the same cycle only on separate beats. At most 1 outstanding beat.
- DONE (1 cycle):
  - done_o = 1.
  - Load: vrf_we_o = 1, vrf_waddr_o = captured vd, vrf_wdata_o = buffer.
  - Then go to IDLE.
- Load buffer initialisation: initialised from data_i at accept, so masked-off elements are mask-undisturbed.
- busy_o = 1 in every state except IDLE. req_ready_o = 0 whenever busy.
- Minimum latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - 2 cycles per active beat + 1 DONE cycle.
  - All-masked request: num_beats skip cycles + DONE.
- Reset values: all outputs 0; state IDLE; buffers 0. req_ready_o becomes 1 on the first cycle after reset release.
- Reset mid-operation: immediate return to IDLE; the in-flight beat is abandoned (the memory side shares the reset); no vrf write.
- Unsupported width codes do not exist (2-bit field, fully decoded).

Optional Feature:
- Macro: VLSU_MISALIGN_CHECK_EN.
- Defined: at accept, if req_base_i is not aligned to beat_bits/8, go straight to DONE with err_o = 1, no memory requests, and vrf_we_o = 0.
- Undefined:
  - Base low bits are forced to zero for alignment.
  - err_o is tied 0.

Decomposition:
- Shared package vlsu_pkg holds:
  - the width code enum (E8/E16/E32/E64);
  - the state enum;
  - mem_size constants;
  - functions beat_bits(width) and num_beats(width).
- One sub-module, vlsu_addr_gen (combinational): computes the beat address, mem_size, element index, active flag and last-beat flag from the captured request and the beat index.

Test Plan:
- e32 load, base 0x100, vm = 1, memory returns 0x11111111..0x44444444 -> addresses 0x100/0x104/0x108/0x10C; size 10; vrf_wdata = 0x44444444_33333333_22222222_11111111; vrf_we 1 cycle; done_o with the write.
- e8 store, base 0x200, vm = 0, mask = 0x0005, data_i bytes 0xA0..0xAF -> exactly 2 writes: 0x200 (wdata 0xA0), 0x202 (wdata 0xA2); done_o; no vrf_we.
- e16 load, vm = 0, mask = 0 -> no mem_req; done after 8 skip cycles + 1; vrf_wdata = data_i.
- mem_gnt_i held low 3 cycles on beat 1 -> mem_req/addr/wdata stable for 4 cycles; busy_o = 1, req_ready_o = 0 throughout.
- e64 load, DATA_WIDTH 32, vm = 0, mask = 0x2 -> 2 beats at base+8 and base+12 only; element 0 retains data_i.
- rst_n low after beat 2 of e32 load -> all outputs 0; a new request restarts at beat 0. With the macro defined: base 0x102 e32 -> done_o + err_o, no mem_req.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types and beat-size helpers for the vector load/store sequencer.
package vlsu_pkg;

    typedef enum logic [1:0] {
        E8  = 2'b00,
        E16 = 2'b01,
        E32 = 2'b10,
        E64 = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    // log2 of the beat size in bits: the element size, clamped to the port width.
    function automatic int beat_log2(input width_e w, input int dw = 32);
        int elem_lg;
        elem_lg = 3 + int'(w);
        return (elem_lg < $clog2(dw)) ? elem_lg : $clog2(dw);
    endfunction

    function automatic int beat_bits(input width_e w, input int dw = 32);
        return 1 << beat_log2(w, dw);
    endfunction

    function automatic int num_beats(input width_e w, input int vlen = 128, input int dw = 32);
        return vlen >> beat_log2(w, dw);
    endfunction

endpackage

// File: rtl/vlsu_sequencer_addr_gen.sv
// Combinational beat decode: address, size, mask activity and last-beat flag
// for the captured request at the current beat index.
module vlsu_addr_gen
    import vlsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int VLEN       = 128,
    parameter int IDX_W      = 4
) (
    input  width_e                width_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic                  vm_i,
    input  logic [VLEN/8-1:0]     mask_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [1:0]            size_o,
    output logic                  active_o,
    output logic                  last_o
);

    logic [IDX_W-1:0] elem_idx;

    always_comb begin
        int bl;
        int el;
        bl = beat_log2(width_i, DATA_WIDTH);
        el = 3 + int'(width_i);
        // Address arithmetic wraps naturally at ADDR_WIDTH bits.
        addr_o = base_i + (ADDR_WIDTH'(idx_i) << (bl - 3));
        case (bl)
            3:       size_o = MEM_SIZE_B;
            4:       size_o = MEM_SIZE_H;
            default: size_o = MEM_SIZE_W;
        endcase
        // Split elements (e64 on a 32-bit port) share one mask bit across beats.
        elem_idx = idx_i >> (el - bl);
        active_o = vm_i | mask_i[elem_idx];
        last_o   = (int'(idx_i) == num_beats(width_i, VLEN, DATA_WIDTH) - 1);
    end

endmodule

// File: rtl/vlsu_sequencer.sv
// Unit-stride vector load/store sequencer: one scalar beat at a time on the data port.
// Optional macro VLSU_MISALIGN_CHECK_EN: reject misaligned bases with err_o instead of aligning.
module vlsu_sequencer
    import vlsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int VLEN       = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_store_i,
    input  logic [1:0]            req_width_i,
    input  logic [ADDR_WIDTH-1:0] req_base_i,
    input  logic [4:0]            req_vd_i,
    input  logic                  req_vm_i,
    input  logic [VLEN/8-1:0]     mask_i,
    input  logic [VLEN-1:0]       data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [1:0]            mem_size_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  vrf_we_o,
    output logic [4:0]            vrf_waddr_o,
    output logic [VLEN-1:0]       vrf_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(VLEN / 8);

    state_e                state_q, state_d;
    width_e                width_q, width_d;
    logic                  store_q, store_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [4:0]            vd_q, vd_d;
    logic                  vm_q, vm_d;
    logic [VLEN/8-1:0]     mask_q, mask_d;
    logic [VLEN-1:0]       buf_q, buf_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  ready_q;

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [1:0]            beat_size;
    logic                  beat_active;
    logic                  beat_last;

    vlsu_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .VLEN       (VLEN),
        .IDX_W      (IDX_W)
    ) u_addr_gen (
        .width_i  (width_q),
        .base_i   (base_q),
        .vm_i     (vm_q),
        .mask_i   (mask_q),
        .idx_i    (idx_q),
        .addr_o   (beat_addr),
        .size_o   (beat_size),
        .active_o (beat_active),
        .last_o   (beat_last)
    );

    // Lane of the vector buffer that the current beat reads or writes.
    int                    beat_shift;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] wdata_beat;
    logic [VLEN-1:0]       merged_buf;
    logic [ADDR_WIDTH-1:0] req_align_mask;
`ifdef VLSU_MISALIGN_CHECK_EN
    logic                  req_misaligned;
`endif

    always_comb begin
        beat_shift     = int'(idx_q) << beat_log2(width_q, DATA_WIDTH);
        lane_mask      = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - beat_bits(width_q, DATA_WIDTH));
        wdata_beat     = DATA_WIDTH'(buf_q >> beat_shift) & lane_mask;
        merged_buf     = (buf_q & ~(VLEN'(lane_mask) << beat_shift))
                       | (VLEN'(mem_rdata_i & lane_mask) << beat_shift);
        req_align_mask = (ADDR_WIDTH'(1) << (beat_log2(width_e'(req_width_i), DATA_WIDTH) - 3))
                       - ADDR_WIDTH'(1);
`ifdef VLSU_MISALIGN_CHECK_EN
        req_misaligned = |(req_base_i & req_align_mask);
`endif
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        store_d = store_q;
        base_d  = base_q;
        vd_d    = vd_q;
        vm_d    = vm_q;
        mask_d  = mask_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    width_d = width_e'(req_width_i);
                    store_d = req_is_store_i;
                    vd_d    = req_vd_i;
                    vm_d    = req_vm_i;
                    mask_d  = mask_i;
                    buf_d   = data_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef VLSU_MISALIGN_CHECK_EN
                    base_d  = req_base_i;
                    if (req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
`else
                    base_d  = req_base_i & ~req_align_mask;
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (beat_active) begin
                    if (mem_gnt_i) state_d = S_WAIT;
                end else if (beat_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if (!store_q) buf_d = merged_buf;
                    if (beat_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_size_o  = '0;
        mem_wdata_o = '0;
        vrf_we_o    = 1'b0;
        vrf_waddr_o = '0;
        vrf_wdata_o = '0;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        req_ready_o = ready_q && (state_q == S_IDLE);
`ifdef VLSU_MISALIGN_CHECK_EN
        err_o       = (state_q == S_DONE) && err_q;
`else
        err_o       = 1'b0;
`endif
        if (state_q == S_ISSUE && beat_active) begin
            mem_req_o  = 1'b1;
            mem_we_o   = store_q;
            mem_addr_o = beat_addr;
            mem_size_o = beat_size;
            if (store_q) mem_wdata_o = wdata_beat;
        end
        if (state_q == S_DONE && !store_q && !err_q) begin
            vrf_we_o    = 1'b1;
            vrf_waddr_o = vd_q;
            vrf_wdata_o = buf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            width_q <= E8;
            store_q <= 1'b0;
            base_q  <= '0;
            vd_q    <= '0;
            vm_q    <= 1'b0;
            mask_q  <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            store_q <= store_d;
            base_q  <= base_d;
            vd_q    <= vd_d;
            vm_q    <= vm_d;
            mask_q  <= mask_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

endmodule
